// File: rtl/ordenator_oet_pkg.sv
// Shared types and width helpers for the odd-even transposition sorter.
// Pure declarations: no latency, no backpressure.
package ordenator_oet_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SORT = 1'b1
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ordenator_oet_if.sv
// Request/result bundle of the sorter: key vector in, sorted keys + permutation out.
// Wiring only: no latency; start is simply ignored while busy is high.
interface ordenator_oet_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_SIZE  = 9
);
    import ordenator_oet_pkg::*;

    localparam int IDX_W = idx_w(DATA_SIZE);
    localparam int CNT_W = cnt_w(DATA_SIZE);

    logic                                  start_i;
    logic                                  descend_i;
    logic [DATA_SIZE-1:0][DATA_WIDTH-1:0]  numbers_i;
    logic [DATA_SIZE-1:0][DATA_WIDTH-1:0]  numbers_o;
    logic [DATA_SIZE-1:0][IDX_W-1:0]       index_o;
    logic [CNT_W-1:0]                      phases_o;
    logic                                  busy_o;
    logic                                  done_o;

    modport master (
        output start_i, descend_i, numbers_i,
        input  numbers_o, index_o, phases_o, busy_o, done_o
    );

    modport slave (
        input  start_i, descend_i, numbers_i,
        output numbers_o, index_o, phases_o, busy_o, done_o
    );

endinterface

// File: rtl/ordenator_oet_cmpx.sv
// Compare-exchange of one adjacent key pair, carrying source indices along.
// Combinational, zero latency, no backpressure.
module ordenator_oet_cmpx #(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = 4
) (
    input  logic [DATA_WIDTH-1:0] key_lo_i,
    input  logic [DATA_WIDTH-1:0] key_hi_i,
    input  logic [IDX_W-1:0]      idx_lo_i,
    input  logic [IDX_W-1:0]      idx_hi_i,
    input  logic                  descend_i,
    input  logic                  signed_i,
    output logic [DATA_WIDTH-1:0] key_lo_o,
    output logic [DATA_WIDTH-1:0] key_hi_o,
    output logic [IDX_W-1:0]      idx_lo_o,
    output logic [IDX_W-1:0]      idx_hi_o,
    output logic                  swapped_o
);

    logic lo_gt_hi;
    logic lo_lt_hi;

    assign lo_gt_hi = signed_i ? ($signed(key_lo_i) > $signed(key_hi_i)) : (key_lo_i > key_hi_i);
    assign lo_lt_hi = signed_i ? ($signed(key_lo_i) < $signed(key_hi_i)) : (key_lo_i < key_hi_i);

    // Strict comparison only: equal keys keep their order, which makes the sort stable.
    assign swapped_o = descend_i ? lo_lt_hi : lo_gt_hi;

    assign key_lo_o = swapped_o ? key_hi_i : key_lo_i;
    assign key_hi_o = swapped_o ? key_lo_i : key_hi_i;
    assign idx_lo_o = swapped_o ? idx_hi_i : idx_lo_i;
    assign idx_hi_o = swapped_o ? idx_lo_i : idx_hi_i;

endmodule

// File: rtl/ordenator_oet.sv
// Odd-even transposition sorter: one compare-exchange phase per clock, early exit on two clean phases.
// Latency 2..DATA_SIZE clocks from accept to done pulse; start is ignored while busy.
module ordenator_oet
    import ordenator_oet_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_SIZE  = 9,
    parameter int SIGNED     = 0
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    ordenator_oet_if.slave bus
);

    localparam int IDX_W = idx_w(DATA_SIZE);
    localparam int CNT_W = cnt_w(DATA_SIZE);
    localparam int NSLOT = DATA_SIZE - 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      phase_q, phase_d;
    logic                  noswap_q, noswap_d;
    logic                  desc_q, desc_d;
    logic                  done_q, done_d;
    logic [CNT_W-1:0]      phases_q, phases_d;
    logic [DATA_WIDTH-1:0] key_q [DATA_SIZE];
    logic [DATA_WIDTH-1:0] key_d [DATA_SIZE];
    logic [IDX_W-1:0]      idx_q [DATA_SIZE];
    logic [IDX_W-1:0]      idx_d [DATA_SIZE];
    logic [DATA_WIDTH-1:0] num_q [DATA_SIZE];
    logic [DATA_WIDTH-1:0] num_d [DATA_SIZE];
    logic [IDX_W-1:0]      ind_q [DATA_SIZE];
    logic [IDX_W-1:0]      ind_d [DATA_SIZE];

    logic [DATA_WIDTH-1:0] lo_key [NSLOT];
    logic [DATA_WIDTH-1:0] hi_key [NSLOT];
    logic [IDX_W-1:0]      lo_idx [NSLOT];
    logic [IDX_W-1:0]      hi_idx [NSLOT];
    logic [NSLOT-1:0]      sw;
    logic [DATA_WIDTH-1:0] key_nxt [DATA_SIZE];
    logic [IDX_W-1:0]      idx_nxt [DATA_SIZE];
    logic                  any_swap;
    logic                  finish;

    // One comparator per adjacent slot; the phase parity selects which slots are live.
    for (genvar j = 0; j < NSLOT; j++) begin : g_slot
        logic swapped;

        ordenator_oet_cmpx #(
            .DATA_WIDTH (DATA_WIDTH),
            .IDX_W      (IDX_W)
        ) u_cmpx (
            .key_lo_i  (key_q[j]),
            .key_hi_i  (key_q[j+1]),
            .idx_lo_i  (idx_q[j]),
            .idx_hi_i  (idx_q[j+1]),
            .descend_i (desc_q),
            .signed_i  (SIGNED != 0),
            .key_lo_o  (lo_key[j]),
            .key_hi_o  (hi_key[j]),
            .idx_lo_o  (lo_idx[j]),
            .idx_hi_o  (hi_idx[j]),
            .swapped_o (swapped)
        );

        assign sw[j] = swapped && (phase_q[0] == 1'(j % 2));
    end

    always_comb begin
        key_nxt = key_q;
        idx_nxt = idx_q;
        for (int j = 0; j < NSLOT; j++) begin
            if (sw[j]) begin
                key_nxt[j]   = lo_key[j];
                key_nxt[j+1] = hi_key[j];
                idx_nxt[j]   = lo_idx[j];
                idx_nxt[j+1] = hi_idx[j];
            end
        end
    end

    assign any_swap = |sw;
    // noswap_q is cleared on accept, so phase 0 alone can never end the sort early.
    assign finish   = (phase_q == CNT_W'(DATA_SIZE - 1)) || (!any_swap && noswap_q);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        noswap_d = noswap_q;
        desc_d   = desc_q;
        done_d   = 1'b0;
        phases_d = phases_q;
        key_d    = key_q;
        idx_d    = idx_q;
        num_d    = num_q;
        ind_d    = ind_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    for (int i = 0; i < DATA_SIZE; i++) begin
                        key_d[i] = bus.numbers_i[i];
                        idx_d[i] = IDX_W'(i);
                    end
                    desc_d   = bus.descend_i;
                    phase_d  = '0;
                    noswap_d = 1'b0;
                    state_d  = SORT;
                end
            end
            SORT: begin
                key_d    = key_nxt;
                idx_d    = idx_nxt;
                phase_d  = phase_q + CNT_W'(1);
                noswap_d = !any_swap;
                if (finish) begin
                    num_d    = key_nxt;
                    ind_d    = idx_nxt;
                    phases_d = phase_q + CNT_W'(1);
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            noswap_q <= 1'b0;
            desc_q   <= 1'b0;
            done_q   <= 1'b0;
            phases_q <= '0;
            for (int i = 0; i < DATA_SIZE; i++) begin
                key_q[i] <= '0;
                idx_q[i] <= IDX_W'(i);
                num_q[i] <= '0;
                ind_q[i] <= IDX_W'(i);
            end
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            noswap_q <= noswap_d;
            desc_q   <= desc_d;
            done_q   <= done_d;
            phases_q <= phases_d;
            key_q    <= key_d;
            idx_q    <= idx_d;
            num_q    <= num_d;
            ind_q    <= ind_d;
        end
    end

    for (genvar i = 0; i < DATA_SIZE; i++) begin : g_out
        assign bus.numbers_o[i] = num_q[i];
        assign bus.index_o[i]   = ind_q[i];
    end

    assign bus.phases_o = phases_q;
    assign bus.busy_o   = (state_q == SORT);
    assign bus.done_o   = done_q;

endmodule

// File: tb/tb_ordenator_oet.sv
// Bench for the odd-even sorter: random and directed vectors against a rank-based stable-sort model.
// Four instances cover DATA_SIZE 9, 5, 4 (signed) and 2.
module tb_ordenator_oet;

    logic clk = 1'b0;
    logic rstn;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ordenator_oet_if #(.DATA_WIDTH(8), .DATA_SIZE(9)) if9 ();
    ordenator_oet_if #(.DATA_WIDTH(8), .DATA_SIZE(5)) if5 ();
    ordenator_oet_if #(.DATA_WIDTH(8), .DATA_SIZE(4)) if4 ();
    ordenator_oet_if #(.DATA_WIDTH(8), .DATA_SIZE(2)) if2 ();

    ordenator_oet #(.DATA_WIDTH(8), .DATA_SIZE(9), .SIGNED(0)) u9 (.clk_i(clk), .rstn_i(rstn), .bus(if9));
    ordenator_oet #(.DATA_WIDTH(8), .DATA_SIZE(5), .SIGNED(0)) u5 (.clk_i(clk), .rstn_i(rstn), .bus(if5));
    ordenator_oet #(.DATA_WIDTH(8), .DATA_SIZE(4), .SIGNED(1)) u4 (.clk_i(clk), .rstn_i(rstn), .bus(if4));
    ordenator_oet #(.DATA_WIDTH(8), .DATA_SIZE(2), .SIGNED(0)) u2 (.clk_i(clk), .rstn_i(rstn), .bus(if2));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stable order by rank: an element's slot is the count of keys that must precede it.
    function automatic void ref_order(input int n, input bit desc, input int v[9], output int pos[9]);
        for (int i = 0; i < 9; i++) pos[i] = 0;
        for (int i = 0; i < n; i++) begin
            int r = 0;
            for (int j = 0; j < n; j++) begin
                if ((desc ? v[j] > v[i] : v[j] < v[i]) || (v[j] == v[i] && j < i)) r++;
            end
            pos[r] = i;
        end
    endfunction

    // Phase count: replay alternating passes until two consecutive clean passes or n passes.
    function automatic int ref_phases(input int n, input bit desc, input int v[9]);
        int a[9];
        bit prev_clean = 1'b0;
        a = v;
        for (int p = 0; p < n; p++) begin
            bit sw = 1'b0;
            for (int j = p % 2; j + 1 < n; j += 2) begin
                if (desc ? a[j] < a[j+1] : a[j] > a[j+1]) begin
                    int t = a[j];
                    a[j] = a[j+1];
                    a[j+1] = t;
                    sw = 1'b1;
                end
            end
            if ((!sw && prev_clean) || p == n - 1) return p + 1;
            prev_clean = !sw;
        end
        return n;
    endfunction

    // Called at a falling edge; returns at the falling edge where done_o is seen.
    task automatic run9(input logic [7:0] k[9], input bit desc, input bit noisy);
        int v[9];
        int pos[9];
        int ph;
        int lat;
        logic [71:0] en;
        logic [35:0] ei;
        for (int i = 0; i < 9; i++) v[i] = int'(k[i]);
        ref_order(9, desc, v, pos);
        ph = ref_phases(9, desc, v);
        for (int r = 0; r < 9; r++) begin
            en[r*8 +: 8] = k[pos[r]];
            ei[r*4 +: 4] = 4'(pos[r]);
        end
        for (int i = 0; i < 9; i++) if9.numbers_i[i] = k[i];
        if9.descend_i = desc;
        if9.start_i   = 1'b1;
        @(negedge clk);
        if9.start_i = 1'b0;
        chk("busy_after_accept", if9.busy_o, 1'b1);
        lat = 0;
        while (!if9.done_o && lat < 20) begin
            if (noisy) begin
                if9.start_i   = 1'($urandom % 2);
                if9.descend_i = ~desc;
                for (int i = 0; i < 9; i++) if9.numbers_i[i] = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        if9.start_i = 1'b0;
        chk("latency", lat, ph);
        chk("numbers", if9.numbers_o, en);
        chk("index", if9.index_o, ei);
        chk("phases", if9.phases_o, ph);
        if (noisy) begin
            @(negedge clk);
            chk("single_done", if9.done_o, 1'b0);
            chk("no_restart", if9.busy_o, 1'b0);
            chk("hold_numbers", if9.numbers_o, en);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] k[9];
        logic [35:0] rst_idx;
        int lat;
        int dones;
        int v[9];
        int ph;

        if9.start_i = 0; if9.descend_i = 0; if9.numbers_i = '0;
        if5.start_i = 0; if5.descend_i = 0; if5.numbers_i = '0;
        if4.start_i = 0; if4.descend_i = 0; if4.numbers_i = '0;
        if2.start_i = 0; if2.descend_i = 0; if2.numbers_i = '0;
        for (int i = 0; i < 9; i++) rst_idx[i*4 +: 4] = 4'(i);

        rstn = 1'b1;
        #3 rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_numbers", if9.numbers_o, 72'd0);
        chk("rst_index", if9.index_o, rst_idx);
        chk("rst_phases", if9.phases_o, 4'd0);
        chk("rst_busy", if9.busy_o, 1'b0);
        chk("rst_done", if9.done_o, 1'b0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) k[i] = 8'(9 - i);
        run9(k, 1'b0, 1'b0);
        chk("reverse_phases_9", if9.phases_o, 4'd9);
        @(negedge clk);
        for (int i = 0; i < 9; i++) k[i] = 8'(i + 1);
        run9(k, 1'b0, 1'b0);
        chk("sorted_phases_2", if9.phases_o, 4'd2);
        @(negedge clk);

        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 9; i++) k[i] = (t % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            run9(k, 1'($urandom % 2), (t % 5 == 4));
            if ($urandom % 2 == 1) @(negedge clk);
        end
        @(negedge clk);

        // Abort mid-sort with reset, then confirm a clean restart.
        for (int i = 0; i < 9; i++) k[i] = 8'(9 - i);
        for (int i = 0; i < 9; i++) if9.numbers_i[i] = k[i];
        if9.descend_i = 1'b0;
        if9.start_i   = 1'b1;
        @(negedge clk);
        if9.start_i = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort_numbers", if9.numbers_o, 72'd0);
        chk("abort_index", if9.index_o, rst_idx);
        chk("abort_phases", if9.phases_o, 4'd0);
        chk("abort_busy", if9.busy_o, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (if9.done_o) dones++;
        end
        chk("abort_no_done", dones, 0);
        for (int i = 0; i < 9; i++) k[i] = 8'($urandom);
        run9(k, 1'b1, 1'b0);
        @(negedge clk);

        // DATA_SIZE=5, duplicates, descending.
        if5.numbers_i = {8'd3, 8'd1, 8'd5, 8'd3, 8'd5};
        if5.descend_i = 1'b1;
        if5.start_i   = 1'b1;
        @(negedge clk);
        if5.start_i = 1'b0;
        lat = 0;
        while (!if5.done_o && lat < 20) begin @(negedge clk); lat++; end
        v = '{5, 3, 5, 1, 3, 0, 0, 0, 0};
        ph = ref_phases(5, 1'b1, v);
        chk("dup5_latency", lat, ph);
        chk("dup5_phases", if5.phases_o, ph);
        chk("dup5_numbers", if5.numbers_o, {8'd1, 8'd3, 8'd3, 8'd5, 8'd5});
        chk("dup5_index", if5.index_o, {3'd3, 3'd4, 3'd1, 3'd2, 3'd0});
        @(negedge clk);

        // DATA_SIZE=4, signed keys, ascending.
        if4.numbers_i = {8'hFF, 8'h00, 8'h7F, 8'h80};
        if4.descend_i = 1'b0;
        if4.start_i   = 1'b1;
        @(negedge clk);
        if4.start_i = 1'b0;
        lat = 0;
        while (!if4.done_o && lat < 20) begin @(negedge clk); lat++; end
        chk("signed4_timeout", (lat < 20), 1'b1);
        chk("signed4_numbers", if4.numbers_o, {8'h7F, 8'h00, 8'hFF, 8'h80});
        chk("signed4_index", if4.index_o, {2'd1, 2'd2, 2'd3, 2'd0});
        @(negedge clk);

        // DATA_SIZE=2: one swapped pair, then an already-ordered pair.
        if2.numbers_i = {8'd2, 8'd7};
        if2.start_i   = 1'b1;
        @(negedge clk);
        if2.start_i = 1'b0;
        lat = 0;
        while (!if2.done_o && lat < 20) begin @(negedge clk); lat++; end
        chk("pair2_timeout", (lat < 20), 1'b1);
        chk("pair2_numbers", if2.numbers_o, {8'd7, 8'd2});
        chk("pair2_index", if2.index_o, 2'b01);
        @(negedge clk);
        if2.numbers_i = {8'd9, 8'd4};
        if2.start_i   = 1'b1;
        @(negedge clk);
        if2.start_i = 1'b0;
        lat = 0;
        while (!if2.done_o && lat < 20) begin @(negedge clk); lat++; end
        chk("pair2_sorted_latency", lat, 2);
        chk("pair2_sorted_phases", if2.phases_o, 2'd2);
        chk("pair2_sorted_numbers", if2.numbers_o, {8'd9, 8'd4});
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
